gesture_flag_ctrl: RTL and testbench

- Upstream control stage for the six-digit dynamic seven-segment display driver.
- Consumes decoded gesture words from the PAJ7620 I2C reader and produces the 2-bit display mode `flag` for the display driver.
- Produces a timed buzzer enable for the beep driver.
- Implements the run/stop mode state machine, multi-gesture rejection, a post-gesture lockout window and an inactivity timeout.

---
 rtl/gesture_flag_ctrl.sv | 72 +++++++
 tb/tb_gesture_flag_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/gesture_flag_ctrl.sv
// gesture_flag_ctrl: gesture-driven run/stop mode FSM with beep lockout, error pulse and inactivity timeout
module gesture_flag_ctrl #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned BEEP_CYCLES    = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       gest_valid,
  input  logic [8:0] gest_data,
  output logic [1:0] flag,
  output logic       beep_en,
  output logic       gest_err
);
  localparam int BW = $clog2(BEEP_CYCLES > 1 ? BEEP_CYCLES : 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES > 1 ? TIMEOUT_CYCLES : 2);
  localparam logic [BW-1:0] B_LAST = BW'(BEEP_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  if (CLK_FREQ == 0 || BEEP_CYCLES == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("gesture_flag_ctrl: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE = 2'b00, STOP = 2'b01, RUN = 2'b10} state_e;
  state_e state_q, state_d;
  logic [1:0] flag_q, flag_d;
  logic beep_q, beep_d, err_q, err_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic open, up, down, wave, accept, reject, tc, b_last;
  assign open   = gest_valid & ~beep_q;
  assign up     = gest_data == 9'h001;
  assign down   = gest_data == 9'h002;
  assign wave   = gest_data == 9'h100;
  assign accept = open & (up | down | wave);
  // zero or multiple set bits both fail the one-hot test
  assign reject = open & ((gest_data == 9'h000) | ((gest_data & (gest_data - 9'h001)) != 9'h000));
  assign tc     = (state_q == RUN) & (tcnt_q == T_LAST);
  assign b_last = bcnt_q == B_LAST;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      flag_q  <= 2'b00;
      beep_q  <= 1'b0;
      err_q   <= 1'b0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      beep_q  <= beep_d;
      err_q   <= err_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end
  // an accepted gesture takes priority over a coincident timeout
  always_comb begin
    state_d = !accept ? (tc ? STOP : state_q) :
              up      ? RUN :
              down    ? STOP :
              (state_q == RUN ? STOP : RUN);
    tcnt_d  = (accept || tc || state_q != RUN) ? '0 : tcnt_q + 1'b1;
    beep_d  = accept | (beep_q & ~b_last);
    bcnt_d  = (beep_q && !b_last) ? bcnt_q + 1'b1 : '0;
    err_d   = reject;
  end
  always_comb begin
    flag_d = state_d == RUN ? 2'b10 : state_d == STOP ? 2'b01 : 2'b00;
  end
  assign flag     = flag_q;
  assign beep_en  = beep_q;
  assign gest_err = err_q;
endmodule

// File: tb/tb_gesture_flag_ctrl.sv
// tb_gesture_flag_ctrl: directed and randomized gesture streams checked against a cycle-level mode model
module tb_gesture_flag_ctrl;
  localparam int B  = 8;
  localparam int TO = 40;
  logic sys_clk = 1'b0, sys_rst = 1'b1, gest_valid = 1'b0;
  logic [8:0] gest_data = '0;
  logic [1:0] flag;
  logic beep_en, gest_err;
  int n_checks = 0, n_fail = 0, cyc = 0, beep_hi = 0;
  int m_mode = 0, m_beep = 0, m_run = 0;
  bit m_err = 0;
  gesture_flag_ctrl #(.CLK_FREQ(50_000_000), .BEEP_CYCLES(B), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gest_valid(gest_valid), .gest_data(gest_data),
    .flag(flag), .beep_en(beep_en), .gest_err(gest_err)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  // mode 0 idle, 1 stopped, 2 running; m_beep = beep cycles still to come; m_run = cycles in RUN since last gesture
  task automatic model(input bit r, input bit v, input logic [8:0] d);
    bit open, acc;
    int nm;
    if (r) begin
      m_mode = 0; m_beep = 0; m_err = 0; m_run = 0;
      return;
    end
    open = v && m_beep == 0;
    acc = open && (d == 9'h001 || d == 9'h002 || d == 9'h100);
    m_err = open && $countones(d) != 1;
    nm = m_mode;
    if (acc) nm = d == 9'h001 ? 2 : d == 9'h002 ? 1 : (m_mode == 2 ? 1 : 2);
    else if (m_mode == 2 && m_run == TO - 1) nm = 1;
    m_run = (acc || nm != 2) ? 0 : m_run + 1;
    m_beep = acc ? B : (m_beep > 0 ? m_beep - 1 : 0);
    m_mode = nm;
  endtask
  task automatic step(input bit r, input bit v, input logic [8:0] d);
    sys_rst = r; gest_valid = v; gest_data = d;
    @(posedge sys_clk);
    model(r, v, d);
    #1;
    cyc++;
    if (beep_en) beep_hi++;
    check("flag", int'(flag), m_mode);
    check("beep_en", int'(beep_en), int'(m_beep > 0));
    check("gest_err", int'(gest_err), int'(m_err));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 9'h000);
  endtask
  task automatic gest(input logic [8:0] d);
    step(0, 1, d);
  endtask
  initial begin
    logic [8:0] d;
    int dens;
    for (int i = 0; i < 3; i++) step(1, 0, 9'h000);
    idle(10);
    beep_hi = 0;
    gest(9'h001); idle(12);
    check("beep_len_up", beep_hi, B);
    check("flag_after_up", int'(flag), 2);
    gest(9'h002); idle(12);
    check("flag_after_down", int'(flag), 1);
    gest(9'h001); idle(10);
    beep_hi = 0;
    gest(9'h100); idle(2); gest(9'h100); idle(10);
    check("beep_len_wave", beep_hi, B);
    check("flag_wave_stop", int'(flag), 1);
    gest(9'h100); idle(10);
    check("flag_wave_run", int'(flag), 2);
    gest(9'h002); idle(10);
    gest(9'h003); idle(1); gest(9'h000); idle(1); gest(9'h004); idle(2);
    check("flag_after_rejects", int'(flag), 1);
    gest(9'h001); idle(50);
    check("flag_timeout", int'(flag), 1);
    gest(9'h001); idle(39); gest(9'h001); idle(3);
    check("flag_tc_gesture", int'(flag), 2);
    idle(45);
    gest(9'h001); idle(3); step(1, 0, 9'h000);
    check("flag_rst_mid_beep", int'(flag), 0);
    check("beep_rst_mid_beep", int'(beep_en), 0);
    gest(9'h001); idle(12);
    for (int blk = 0; blk < 20; blk++) begin
      dens = (blk % 2) ? 64 : 4;
      for (int i = 0; i < 150; i++) begin
        case ($urandom_range(5))
          0: d = 9'h001;
          1: d = 9'h002;
          2: d = 9'h100;
          3: d = 9'h000;
          4: d = 9'(1 << $urandom_range(8));
          default: d = 9'($urandom);
        endcase
        step($urandom_range(199) == 0, $urandom_range(dens - 1) == 0, d);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
